shiftadd_scheduler: RTL and testbench

SHIFTADD_SCHEDULER -- requirements
Module: shiftadd_scheduler

---
 rtl/shiftadd_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_shiftadd_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shiftadd_scheduler.sv
// Two-requester front end for an external shift-add modular reducer: arbitrates requests,
// sequences the reducer reset/start, bounds the wait with a timeout and returns one response per job.
module shiftadd_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [63:0] req0_x_i,
  input  logic [31:0] req0_m_i,
  input  logic [31:0] req0_m_bl_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [63:0] req1_x_i,
  input  logic [31:0] req1_m_i,
  input  logic [31:0] req1_m_bl_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_data_o,
  output logic        rsp_id_o,
  output logic        rsp_err_o,
  output logic        red_rst_no,
  output logic        red_start_o,
  output logic [63:0] red_x_o,
  output logic [31:0] red_m_o,
  output logic [31:0] red_m_bl_o,
  input  logic [63:0] red_result_i,
  input  logic        red_valid_i,
  output logic        busy_o,
  output logic [15:0] jobs_done_o
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_last_grant;
  logic [15:0] r_timer;
  logic [15:0] r_jobs_done;
  logic [63:0] r_op_x;
  logic [31:0] r_op_m;
  logic [31:0] r_op_bl;
  logic        r_rsp_valid;
  logic [63:0] r_rsp_data;
  logic        r_rsp_id;
  logic        r_rsp_err;
  logic        r_red_start;
  logic        r_busy;

  logic        w_grant;
  logic        w_grant_id;
  logic [63:0] w_sel_x;
  logic [31:0] w_sel_m;
  logic [31:0] w_sel_bl;
  logic        w_bl_ok;
  logic        w_timeout;
  logic        w_rsp_hs;

  // Round-robin pick: a tie goes to the requester that did not win last time.
  always_comb begin
    w_grant_id = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      w_grant_id = ~r_last_grant;
    end else if (req1_valid_i) begin
      w_grant_id = 1'b1;
    end else begin
      w_grant_id = 1'b0;
    end
  end

  assign w_grant   = (r_state == ST_IDLE) && !rst_i && (req0_valid_i || req1_valid_i);
  assign w_sel_x   = w_grant_id ? req1_x_i    : req0_x_i;
  assign w_sel_m   = w_grant_id ? req1_m_i    : req0_m_i;
  assign w_sel_bl  = w_grant_id ? req1_m_bl_i : req0_m_bl_i;
  assign w_bl_ok   = (w_sel_bl >= 32'd2) && (w_sel_bl <= 32'd32);
  assign w_timeout = (r_timer == TIMEOUT_LAST);
  assign w_rsp_hs  = r_rsp_valid && rsp_ready_i;

  // Next-state logic; a valid result beats a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = w_bl_ok ? ST_CLEAR : ST_RESP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (red_valid_i || w_timeout) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (w_rsp_hs) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus the flags derived from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_rsp_valid <= 1'b0;
      r_red_start <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= (w_state_nxt == ST_RESP);
      r_red_start <= (w_state_nxt == ST_START);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Wait timer, zeroed on the way into WAIT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_timer <= 16'd0;
    end else if ((w_state_nxt == ST_WAIT) && (r_state != ST_WAIT)) begin
      r_timer <= 16'd0;
    end else if (r_state == ST_WAIT) begin
      r_timer <= r_timer + 16'd1;
    end else begin
      r_timer <= r_timer;
    end
  end

  // Operand capture and arbitration history; operands stay put until the next grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op_x       <= 64'd0;
      r_op_m       <= 32'd0;
      r_op_bl      <= 32'd0;
      r_last_grant <= 1'b1;
    end else if (w_grant) begin
      r_op_x       <= w_sel_x;
      r_op_m       <= w_sel_m;
      r_op_bl      <= w_sel_bl;
      r_last_grant <= w_grant_id;
    end else begin
      r_op_x       <= r_op_x;
      r_op_m       <= r_op_m;
      r_op_bl      <= r_op_bl;
      r_last_grant <= r_last_grant;
    end
  end

  // Response payload: loaded on reject, result or timeout, then held through RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_data <= 64'd0;
      r_rsp_id   <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else if (w_grant) begin
      r_rsp_id <= w_grant_id;
      if (!w_bl_ok) begin
        r_rsp_data <= 64'd0;
        r_rsp_err  <= 1'b1;
      end
    end else if ((r_state == ST_WAIT) && red_valid_i) begin
      r_rsp_data <= red_result_i;
      r_rsp_err  <= 1'b0;
    end else if ((r_state == ST_WAIT) && w_timeout) begin
      r_rsp_data <= 64'd0;
      r_rsp_err  <= 1'b1;
    end else begin
      r_rsp_data <= r_rsp_data;
      r_rsp_id   <= r_rsp_id;
      r_rsp_err  <= r_rsp_err;
    end
  end

  // Completed-response counter, free-running wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_jobs_done <= 16'd0;
    end else if ((r_state == ST_RESP) && w_rsp_hs) begin
      r_jobs_done <= r_jobs_done + 16'd1;
    end else begin
      r_jobs_done <= r_jobs_done;
    end
  end

  assign req0_ready_o = w_grant && !w_grant_id;
  assign req1_ready_o = w_grant && w_grant_id;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_data_o   = r_rsp_data;
  assign rsp_id_o     = r_rsp_id;
  assign rsp_err_o    = r_rsp_err;
  assign red_rst_no   = ~(rst_i | (r_state == ST_CLEAR));
  assign red_start_o  = r_red_start;
  assign red_x_o      = r_op_x;
  assign red_m_o      = r_op_m;
  assign red_m_bl_o   = r_op_bl;
  assign busy_o       = r_busy;
  assign jobs_done_o  = r_jobs_done;

endmodule

// File: tb/tb_shiftadd_scheduler.sv
// Directed bench for shiftadd_scheduler with a small behavioural reducer (fixed latency, optional hang).
module tb_shiftadd_scheduler;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req0_ready_o, req1_valid_i, req1_ready_o;
  logic [63:0] req0_x_i, req1_x_i;
  logic [31:0] req0_m_i, req0_m_bl_i, req1_m_i, req1_m_bl_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_err_o;
  logic [63:0] rsp_data_o;
  logic        red_rst_no, red_start_o;
  logic [63:0] red_x_o;
  logic [31:0] red_m_o, red_m_bl_o;
  logic [63:0] red_result_i;
  logic        red_valid_i;
  logic        busy_o;
  logic [15:0] jobs_done_o;

  always #5 clk = ~clk;

  shiftadd_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_x_i(req0_x_i), .req0_m_i(req0_m_i), .req0_m_bl_i(req0_m_bl_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_x_i(req1_x_i), .req1_m_i(req1_m_i), .req1_m_bl_i(req1_m_bl_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o),
    .red_rst_no(red_rst_no), .red_start_o(red_start_o),
    .red_x_o(red_x_o), .red_m_o(red_m_o), .red_m_bl_o(red_m_bl_o),
    .red_result_i(red_result_i), .red_valid_i(red_valid_i),
    .busy_o(busy_o), .jobs_done_o(jobs_done_o)
  );

  // Reducer stand-in: answers three cycles after start unless told to hang.
  bit         red_hang = 1'b0;
  logic       red_run;
  logic [3:0] red_cnt;
  always @(posedge clk) begin
    if (!red_rst_no) begin
      red_run <= 1'b0; red_cnt <= 4'd0; red_valid_i <= 1'b0; red_result_i <= 64'd0;
    end else if (red_start_o) begin
      red_run <= 1'b1; red_cnt <= 4'd3; red_valid_i <= 1'b0;
    end else if (red_run && !red_hang && red_cnt == 4'd1) begin
      red_run <= 1'b0; red_valid_i <= 1'b1; red_result_i <= red_x_o % {32'd0, red_m_o};
    end else if (red_run && !red_hang) begin
      red_cnt <= red_cnt - 4'd1; red_valid_i <= 1'b0;
    end else begin
      red_valid_i <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle.
  int clr_cnt = 0, clr_cyc = -1, start_cnt = 0, start_cyc = -1, rv_cyc = -1, rise_cyc = -1;
  bit prev_v = 1'b0;
  always @(negedge clk) begin
    if (!rst_i && !red_rst_no) begin clr_cnt++; clr_cyc = cyc; end
    if (red_start_o) begin start_cnt++; start_cyc = cyc; end
    if (red_valid_i) rv_cyc = cyc;
    if (rsp_valid_o && !prev_v) rise_cyc = cyc;
    prev_v = rsp_valid_o;
  end

  int n_chk = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input bit id, input logic [63:0] x, input logic [31:0] m,
                       input logic [31:0] bl, output int t);
    if (id) begin
      req1_x_i = x; req1_m_i = m; req1_m_bl_i = bl; req1_valid_i = 1'b1;
    end else begin
      req0_x_i = x; req0_m_i = m; req0_m_bl_i = bl; req0_valid_i = 1'b1;
    end
    #1;
    check_eq("grant_ready", 64'({req1_ready_o, req0_ready_o}), id ? 64'd2 : 64'd1);
    t = cyc;
    tick();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    int i = 0;
    while (!rsp_valid_o && i < budget) begin
      tick();
      i++;
    end
    check_eq("rsp_arrive", 64'(rsp_valid_o), 64'd1);
  endtask

  task automatic handshake(input int exp_jobs);
    rsp_ready_i = 1'b1;
    #1;
    check_eq("hs_no_ready", 64'({req0_ready_o, req1_ready_o}), 64'd0);
    tick();
    rsp_ready_i = 1'b0;
    check_eq("hs_idle", 64'({busy_o, rsp_valid_o}), 64'd0);
    check_eq("jobs_done", 64'(jobs_done_o), 64'(exp_jobs));
  endtask

  initial begin
    int t, c0, s0;
    rst_i = 1'b1; rsp_ready_i = 1'b0;
    req0_x_i = 64'd1000; req0_m_i = 32'd127; req0_m_bl_i = 32'd7; req0_valid_i = 1'b1;
    req1_x_i = 64'd1000; req1_m_i = 32'd257; req1_m_bl_i = 32'd9; req1_valid_i = 1'b1;
    repeat (3) tick();

    check_eq("rst_ready", 64'({req0_ready_o, req1_ready_o}), 64'd0);
    check_eq("rst_flags", 64'({busy_o, rsp_valid_o, rsp_id_o, rsp_err_o, red_start_o}), 64'd0);
    check_eq("rst_data", rsp_data_o, 64'd0);
    check_eq("rst_red_rst", 64'(red_rst_no), 64'd0);
    check_eq("rst_jobs", 64'(jobs_done_o), 64'd0);
    check_eq("rst_opnd", red_x_o, 64'd0);

    // Tie straight out of reset: requester 0 first, then 1.
    rst_i = 1'b0;
    #1;
    check_eq("tie_first", 64'({req1_ready_o, req0_ready_o}), 64'd1);
    tick();
    req0_valid_i = 1'b0;
    check_eq("no_overlap", 64'({req1_ready_o, req0_ready_o}), 64'd0);
    check_eq("opnd", {red_x_o[31:0], red_m_o}, {32'd1000, 32'd127});
    check_eq("opnd_bl", 64'(red_m_bl_o), 64'd7);
    wait_rsp(20);
    check_eq("mersenne_data", rsp_data_o, 64'd111);
    check_eq("mersenne_id_err", 64'({rsp_id_o, rsp_err_o}), 64'd0);
    check_eq("rsp_latency", 64'(rise_cyc), 64'(rv_cyc + 1));
    handshake(1);

    check_eq("tie_second", 64'({req1_ready_o, req0_ready_o}), 64'd2);
    t = cyc; c0 = clr_cnt; s0 = start_cnt;
    tick();
    req1_valid_i = 1'b0;
    wait_rsp(20);
    check_eq("fermat_data", rsp_data_o, 64'd229);
    check_eq("fermat_id_err", 64'({rsp_id_o, rsp_err_o}), 64'd2);
    check_eq("clear_once", 64'(clr_cnt - c0), 64'd1);
    check_eq("clear_at", 64'(clr_cyc), 64'(t + 1));
    check_eq("start_once", 64'(start_cnt - s0), 64'd1);
    check_eq("start_at", 64'(start_cyc), 64'(t + 2));
    handshake(2);

    // Timeout with a silent reducer; m_bl=2 is the smallest accepted length.
    red_hang = 1'b1;
    c0 = clr_cnt;
    issue(1'b0, 64'd5, 32'd3, 32'd2, t);
    wait_rsp(30);
    check_eq("tmo_latency", 64'(rise_cyc), 64'(t + 3 + int'(TMO)));
    check_eq("tmo_data", rsp_data_o, 64'd0);
    check_eq("tmo_id_err", 64'({rsp_id_o, rsp_err_o}), 64'd1);
    check_eq("bl2_accepted", 64'(clr_cnt - c0), 64'd1);
    handshake(3);
    red_hang = 1'b0;

    // m_bl=32 upper bound: (2^32+5) mod (2^32-1) = 6.
    issue(1'b0, 64'h0000_0001_0000_0005, 32'hFFFF_FFFF, 32'd32, t);
    wait_rsp(20);
    check_eq("bl32_data", rsp_data_o, 64'd6);
    check_eq("bl32_id_err", 64'({rsp_id_o, rsp_err_o}), 64'd0);
    handshake(4);

    // Rejects: m_bl=0 and m_bl=33 go straight to RESP.
    c0 = clr_cnt; s0 = start_cnt;
    issue(1'b0, 64'd1000, 32'd127, 32'd0, t);
    check_eq("rej0_valid_err", 64'({rsp_valid_o, rsp_id_o, rsp_err_o}), 64'd5);
    check_eq("rej0_data", rsp_data_o, 64'd0);
    check_eq("rej0_at", 64'(rise_cyc), 64'(t + 1));
    handshake(5);
    issue(1'b1, 64'd7, 32'd5, 32'd33, t);
    check_eq("rej33_valid_err", 64'({rsp_valid_o, rsp_id_o, rsp_err_o}), 64'd7);
    handshake(6);
    check_eq("rej_no_pulse", 64'({clr_cnt - c0, start_cnt - s0}), 64'd0);

    // Backpressure: response held for five cycles.
    issue(1'b1, 64'd1000, 32'd127, 32'd7, t);
    wait_rsp(20);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_data", rsp_data_o, 64'd111);
      check_eq("bp_flags", 64'({rsp_valid_o, rsp_id_o, rsp_err_o}), 64'd6);
      tick();
    end
    handshake(7);

    // Reset in the middle of WAIT abandons the job.
    issue(1'b0, 64'd1000, 32'd257, 32'd9, t);
    tick(); tick();
    check_eq("wait_busy", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    tick();
    check_eq("rst_wait_flags", 64'({busy_o, rsp_valid_o, red_rst_no}), 64'd0);
    check_eq("rst_wait_jobs", 64'(jobs_done_o), 64'd0);
    rst_i = 1'b0;
    repeat (12) tick();
    check_eq("abandoned", 64'({busy_o, rsp_valid_o}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
